mux_sel_sequencer: RTL

Upstream driver for the 8:1 bit-select mux (`mux`). It accepts an 8-bit word through a start/ready handshake and holds it on the mux data inputs. It then steps the mux select through all eight indices, holding each for a programmable number of clock cycles, so the mux output carries the word serially. It signals completion with a one-cycle done pulse and returns to idle.

---
 rtl/mux_sel_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mux_sel_sequencer.sv
// Serializing driver for an 8:1 bit-select mux: latches a word on a start/ready
// handshake and steps the select through all eight bits. Build option: MUX_SEQ_MSB_FIRST_EN.
module mux_sel_sequencer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic [7:0] I,
  output logic [2:0] S,
  output logic       valid,
  output logic       done
);

  localparam int unsigned DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [2:0] SEL_FIRST = 3'd7;
  localparam logic [2:0] SEL_LAST  = 3'd0;
`else
  localparam logic [2:0] SEL_FIRST = 3'd0;
  localparam logic [2:0] SEL_LAST  = 3'd7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [2:0] sel_step(input logic [2:0] sel);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return sel - 3'd1;
`else
    return sel + 3'd1;
`endif
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       word_q, word_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  // Next-state logic; abort outranks the divider/select step in RUN.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sel_d   = sel_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          word_d  = data_in;
          sel_d   = SEL_FIRST;
          div_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          if (sel_q == SEL_LAST) begin
            state_d = ST_DONE;
          end else begin
            sel_d = sel_step(sel_q);
            div_d = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status flags decode the next state so they come straight off flops.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      sel_q   <= SEL_FIRST;
      word_q  <= 8'h00;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign I     = word_q;
  assign S     = sel_q;

endmodule
